// File: rtl/div_freq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_freq_pkg : shared constants and helpers for the clock divider  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package div_freq_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;

    function automatic int hz_to_half(input int clk_hz, input int f_out);
        return clk_hz / (2 * f_out) - 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int HALF_1HZ = hz_to_half(CLK_HZ_DEFAULT, 1);
    localparam int HALF_3HZ = hz_to_half(CLK_HZ_DEFAULT, 3);

endpackage
`default_nettype wire

// File: rtl/div_freq_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_freq_ch : one divider channel with shadowed half-period reload |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module div_freq_ch
    import div_freq_pkg::*;
#(
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 8333333
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             one_shot,
    input  logic             fire,
    input  logic             restart,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_clk;
    logic             r_tick;
    logic             r_active;

    logic w_idle;
    logic w_tc;
    logic w_run;

    assign w_idle = one_shot && !r_active;
    assign w_tc   = (r_cnt == r_half);
    assign w_run  = enable && !restart && !w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_half    <= CNT_W'(DEFAULT_HALF);
            r_shadow  <= CNT_W'(DEFAULT_HALF);
            r_pending <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            if (!enable || restart) begin
                r_cnt    <= '0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
                r_active <= 1'b0;
            end else if (w_idle) begin
                // one-shot idle: a fire starts the high phase immediately
                r_cnt    <= '0;
                r_clk    <= fire;
                r_tick   <= fire;
                r_active <= fire;
            end else if (w_tc) begin
                r_cnt <= '0;
                if (one_shot && !r_clk) begin
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                    r_active <= 1'b0;
                end else begin
                    r_clk  <= ~r_clk;
                    r_tick <= ~r_clk;
                end
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end

            // accept and adoption never coincide: accept requires !r_pending
            if (cfg_we) begin
                r_shadow  <= cfg_half;
                r_pending <= 1'b1;
            end else if (r_pending && (!w_run || w_tc)) begin
                r_half    <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    assign pending = r_pending;
    assign clk_out = r_clk;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/div_freq_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_freq_multi : NUM_CH runtime-programmable 50% clock dividers    |
// | Optional DIV_FREQ_STEP_EN adds push-button single-step on ch 0.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module div_freq_multi
    import div_freq_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 26,
    parameter int DEFAULT_HALF = 8333333
) (
    input  logic                        CLOCK_50MHz,
    input  logic                        Reset_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]            cfg_half,
    input  logic [NUM_CH-1:0]           enable,
`ifdef DIV_FREQ_STEP_EN
    input  logic                        step_mode,
    input  logic                        step_btn,
`endif
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           tick
);

    localparam int CH_W = ch_width(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("div_freq_multi: NUM_CH must be 1..8");
    end
    if (CNT_W < 1 || DEFAULT_HALF < 0 || (CNT_W < 31 && DEFAULT_HALF >= (1 << CNT_W))) begin : g_bad_half
        $error("div_freq_multi: DEFAULT_HALF does not fit in CNT_W bits");
    end
    if (CLK_HZ <= 0) begin : g_bad_clk
        $error("div_freq_multi: CLK_HZ must be positive");
    end

    logic w_one_shot;
    logic w_fire;
    logic w_restart;

`ifdef DIV_FREQ_STEP_EN
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_mode_d;

    always_ff @(posedge CLOCK_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_mode_d <= 1'b0;
        end else begin
            r_sync1  <= step_btn;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_mode_d <= step_mode;
        end
    end

    assign w_one_shot = step_mode;
    assign w_restart  = step_mode ^ r_mode_d;
    assign w_fire     = step_mode && r_sync2 && !r_sync3;
`else
    assign w_one_shot = 1'b0;
    assign w_restart  = 1'b0;
    assign w_fire     = 1'b0;
`endif

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_cfg_we;

    // out-of-range channel selects stay ready so the request is drained
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~w_pending[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        div_freq_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk      (CLOCK_50MHz),
            .rst_n    (Reset_n),
            .enable   (enable[i]),
            .one_shot ((i == 0) ? w_one_shot : 1'b0),
            .fire     ((i == 0) ? w_fire : 1'b0),
            .restart  ((i == 0) ? w_restart : 1'b0),
            .cfg_we   (w_cfg_we[i]),
            .cfg_half (cfg_half),
            .pending  (w_pending[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_div_freq_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_div_freq_multi : directed scoreboard bench for div_freq_multi   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_div_freq_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 26;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [0:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic [1:0]       enable;
    logic [1:0]       clk_out;
    logic [1:0]       tick;
`ifdef DIV_FREQ_STEP_EN
    logic             step_mode;
    logic             step_btn;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp0[$];
    int exp1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_freq_multi #(
        .CLK_HZ       (50_000_000),
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (3)
    ) dut (
        .CLOCK_50MHz (clk),
        .Reset_n     (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .enable      (enable),
`ifdef DIV_FREQ_STEP_EN
        .step_mode   (step_mode),
        .step_btn    (step_btn),
`endif
        .clk_out     (clk_out),
        .tick        (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int first, input int period, input int n);
        for (int k = 0; k < n; k++) begin
            if (ch == 0) exp0.push_back(first + k * period);
            else         exp1.push_back(first + k * period);
        end
    endtask

    task automatic mon_ch(input string name, input logic t, input logic co, inout int q[$]);
        int e;
        if (q.size() > 0 && q[0] < cyc) begin
            check({name, "_missed_tick"}, cyc, q[0]);
            void'(q.pop_front());
        end
        if (t) begin
            e = (q.size() > 0) ? q.pop_front() : -1;
            check({name, "_tick_cycle"}, cyc, e);
            check({name, "_clk_at_tick"}, co, 1);
        end
    endtask

    task automatic cyc1();
        @(negedge clk);
        mon_ch("ch0", tick[0], clk_out[0], exp0);
        mon_ch("ch1", tick[1], clk_out[1], exp1);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) cyc1();
    endtask

    initial begin
        int b;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_half  = '0;
        enable    = 2'b11;
`ifdef DIV_FREQ_STEP_EN
        step_mode = 1'b0;
        step_btn  = 1'b0;
`endif
        repeat (3) cyc1();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_cfg_ready0", cfg_ready, 1);
        cfg_ch = 1'b1;
        #1 check("rst_cfg_ready1", cfg_ready, 1);
        cfg_ch = 1'b0;

        // free run with DEFAULT_HALF=3: rise at +4, period 8
        rst_n = 1'b1;
        b = cyc;
        push(0, b + 4, 8, 3);
        push(1, b + 4, 8, 2);
        run_to(b + 3);  check("first_rise_pre", clk_out[0], 0);
        run_to(b + 4);  check("first_rise", clk_out, 2'b11);
        run_to(b + 8);  check("first_fall", clk_out, 0);

        // reprogram ch1 to half=1 mid half-period
        run_to(b + 14);
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 1;
        #1 check("cfg1_ready_before", cfg_ready, 1);
        push(1, b + 18, 4, 10);
        run_to(b + 15);
        cfg_valid = 1'b0;
        #1 check("cfg1_ready_pending", cfg_ready, 0);
        run_to(b + 16);
        check("cfg1_ready_adopted", cfg_ready, 1);
        check("cfg1_fall", clk_out[1], 0);

        // ch0 accept coincides with a terminal count
        run_to(b + 23);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 1;
        #1 check("cfg0_ready_before", cfg_ready, 1);
        push(0, b + 28, 4, 2);
        run_to(b + 24);
        cfg_valid = 1'b0;
        check("same_cycle_fall", clk_out[0], 0);
        #1 check("cfg0_ready_pending", cfg_ready, 0);
        run_to(b + 27); check("no_runt_low", clk_out[0], 0);
        run_to(b + 28); check("cfg0_ready_adopted", cfg_ready, 1);
        run_to(b + 30); check("new_half_fall", clk_out[0], 0);

        // disable ch0 while high, reload half=3 while disabled, re-enable
        run_to(b + 32);
        check("en_drop_high", clk_out[0], 1);
        enable[0] = 1'b0;
        run_to(b + 33); check("en_drop_low", clk_out[0], 0);
        run_to(b + 34);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 3;
        run_to(b + 35);
        cfg_valid = 1'b0;
        #1 check("dis_ready_pending", cfg_ready, 0);
        run_to(b + 36);
        check("dis_ready_adopted", cfg_ready, 1);
        enable[0] = 1'b1;
        push(0, b + 40, 8, 3);
        run_to(b + 39); check("reen_pre", clk_out[0], 0);
        run_to(b + 40); check("reen_rise", clk_out[0], 1);
        run_to(b + 56);
        check("q0_empty_run", exp0.size(), 0);
        check("q1_empty_run", exp1.size(), 0);

        // asynchronous reset between clock edges
        check("pre_reset_tick", tick, 2'b01);
        #1 rst_n = 1'b0;
        #1 check("async_clk_out", clk_out, 0);
        check("async_tick", tick, 0);
        repeat (2) cyc1();
        rst_n = 1'b1;
        b = cyc;
        push(0, b + 4, 8, 2);
        push(1, b + 4, 8, 2);
        run_to(b + 13);
        check("q0_empty_reset", exp0.size(), 0);
        check("q1_empty_reset", exp1.size(), 0);

`ifdef DIV_FREQ_STEP_EN
        begin : step_phase
            int p;
            step_mode = 1'b1;
            push(1, b + 20, 8, 3);
            run_to(b + 16);
            check("step_idle", clk_out[0], 0);
            p = cyc;
            step_btn = 1'b1;
            push(0, p + 3, 1, 1);
            run_to(p + 1);  step_btn = 1'b0;
            run_to(p + 2);  check("step_pre", clk_out[0], 0);
            run_to(p + 3);  check("step_rise", clk_out[0], 1);
            run_to(p + 5);  step_btn = 1'b1;
            run_to(p + 6);  step_btn = 1'b0;
            check("step_high_end", clk_out[0], 1);
            run_to(p + 7);  check("step_fall", clk_out[0], 0);
            run_to(p + 11); check("step_low", clk_out[0], 0);
            run_to(p + 20); check("step_ignored", clk_out[0], 0);
            check("q0_empty_step", exp0.size(), 0);
            check("q1_empty_step", exp1.size(), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_freq_multi.md
# div_freq_multi

Parametrised multi-channel clock divider that replaces the fixed single-output divider in the board top level. It produces NUM_CH independent 50 %-duty divided clocks plus single-cycle tick strobes from the 50 MHz board clock. Each channel's divide ratio is reprogrammable at runtime through a valid/ready port. An optional manual single-step mode on channel 0 lets the RISC-V core be clocked one cycle per button press.

## Interface
- CLK_HZ, 50_000_000: input clock frequency; used only by package helper constants.
- NUM_CH, 2: number of output channels, 1..8.
- CNT_W, 26: counter and half-period width.
- DEFAULT_HALF, 8333333: reset half-period terminal count for every channel. Must be < 2**CNT_W; elaboration error otherwise.

Ports:
- CLOCK_50MHz  in  1  system clock.
- Reset_n  in  1  reset; asynchronous, active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  request accepted on cfg_valid && cfg_ready.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values ≥ NUM_CH are accepted and discarded.
- cfg_half  in  CNT_W  new half-period terminal count.
- enable  in  NUM_CH  per-channel run enable.
- clk_out  out  NUM_CH  divided square waves.
- tick  out  NUM_CH  one-cycle pulse coincident with each clk_out rising edge.
- step_mode  in  1  (DIV_FREQ_STEP_EN only) channel 0 manual mode.
- step_btn  in  1  (DIV_FREQ_STEP_EN only) raw asynchronous push-button.

## Operation
- Each channel has the following registers: counter, half (active terminal count), shadow, pending.
- Running (enable=1):
  - The counter increments each cycle.
  - When counter == half: counter←0 and clk_out inverts.
  - Period = 2·(half+1) cycles; f_out = CLK_HZ / (2·(half+1)).
  - half=0 gives divide-by-2.
- tick is registered. It is 1 for exactly the cycle in which clk_out has just gone 0→1; it is never high on a falling toggle.
- Disabled (enable=0):
  - counter←0, clk_out←0, tick←0 at the next edge.
  - On re-enable, counting starts from 0, so the first rise occurs half+1 cycles later.
- Configuration:
  - cfg_ready = ~pending[cfg_ch], combinational.
  - On accept: shadow←cfg_half, pending←1.
  - A pending value is adopted (half←shadow, pending←0) on the next terminal-count edge if the channel is running, or on the next edge if it is disabled.
  - This keeps clk_out glitch-free: no period shorter than min(old,new) half-period.
  - If accept and terminal count fall in the same cycle, the toggle uses the old half and the new value is adopted at the following terminal count.
- Reset values (async, on Reset_n=0):
  - counter=0, clk_out=0, tick=0, half=DEFAULT_HALF, shadow=DEFAULT_HALF, pending=0.
  - cfg_ready=1 after reset.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.

## Timing
- Output latency relative to the counter is one edge: clk_out/tick change on the edge that sees counter==half.
- First rising edge after reset release (enabled): half+1 cycles.
- Configuration adoption latency is at most half+1 cycles when running, and 1 cycle when disabled.
- All outputs are registered; no combinational path from any input to clk_out or tick.
- cfg_ready is the only combinational output (from cfg_ch and pending).

## Configuration
- Macro: DIV_FREQ_STEP_EN.
- Defined:
  - step_btn passes through a 2-FF synchroniser plus a rising-edge detector.
  - With step_mode=1, channel 0 ignores free-run and idles with clk_out[0]=0.
  - A detected edge starts one full period: clk_out[0] high for half+1 cycles, with tick[0] in its first cycle, then low for half+1 cycles.
  - Edges arriving during that period are ignored.
  - Toggling step_mode restarts channel 0 from counter=0, clk_out=0.
  - Step mode requires enable[0]=1.
- Undefined: step_mode and step_btn ports are absent, and channel 0 behaves identically to the others.

## Structure
- Package div_freq_pkg holds:
  - CLK_HZ_DEFAULT.
  - Function hz_to_half(clk_hz, f_out) returning clk_hz/(2·f_out)−1.
  - Named constants HALF_1HZ (24999999) and HALF_3HZ (8333332).
- Sub-module div_freq_ch: one channel (counter, half, shadow, pending, toggle, tick).
  - Instantiated NUM_CH times by generate.
  - The step logic lives in the top and drives channel 0's step controls.

## Test plan
- Reset with DEFAULT_HALF=3, enable=all 1 → clk_out rises 4 cycles after Reset_n rises; period 8; tick one cycle every 8 cycles.
- Accept cfg_ch=1, cfg_half=1 mid half-period → cfg_ready low until ch1's next terminal count; period then 4; ch0 unaffected at 8.
- cfg accept in the same cycle as a terminal count → the current toggle uses half=3, next half-period uses the new value; no runt pulse.
- Drop enable[0] while clk_out[0]=1 → clk_out[0]=0 next cycle; re-assert → first rise 4 cycles later.
- DIV_FREQ_STEP_EN, step_mode=1, single step_btn pulse:
  - clk_out[0] rises 3 cycles after the press (2-FF sync + edge detect) and stays high 4 cycles, then low 4 cycles.
  - A second press during that window produces nothing.
- Assert Reset_n low mid-period without a clock edge → clk_out=0 and tick=0 immediately; after release, half is back to 3 on all channels.
